// File: rtl/stack_pkg.sv
// Shared types and helpers for the parameterised LIFO stack.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PEEK,
        OP_REPL,
        OP_POP,
        OP_PUSH
    } op_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Address wraps past DEPTH-1 only when the stack is empty; read is unused then.
    assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/param_stack.sv
// LIFO stack with peek, replace, registered result and overflow/underflow pulses.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    output logic [WIDTH-1:0] resStk,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    op_e              op;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             is_full, is_empty;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] top_data;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign top_addr = AW'(count_q - CNT_W'(1));

    always_comb begin
        op = OP_IDLE;
        if (tos) begin
            op = OP_PEEK;
        end else if (push && pop) begin
            op = OP_REPL;
        end else if (pop) begin
            op = OP_POP;
        end else if (push) begin
            op = OP_PUSH;
        end
    end

    always_comb begin
        count_d = count_q;
        res_d   = res_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        we      = 1'b0;
        waddr   = top_addr;
        case (op)
            OP_PEEK: begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    res_d   = top_data;
                    valid_d = 1'b1;
                end
            end
            OP_REPL: begin
                valid_d = 1'b1;
                // Empty replace bypasses storage and just echoes the word.
                if (is_empty) begin
                    res_d = dataIn;
                end else begin
                    res_d = top_data;
                    we    = 1'b1;
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    res_d   = top_data;
                    count_d = count_q - CNT_W'(1);
                    valid_d = 1'b1;
                end
            end
            OP_PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    waddr   = AW'(count_q);
                    res_d   = dataIn;
                    count_d = count_q + CNT_W'(1);
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we && !rst),
        .waddr_i (waddr),
        .wdata_i (dataIn),
        .raddr_i (top_addr),
        .rdata_o (top_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign resStk = res_q;
    assign valid  = valid_q;
    assign count  = count_q;
    assign full   = is_full;
    assign empty  = is_empty;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
